// File: rtl/cmp_mon_pkg.sv
// Shared types and constants for the cmp_hysteresis_mon threshold monitor.
package cmp_mon_pkg;

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM    = 2'd1,
        HIGH   = 2'd2,
        DISARM = 2'd3
    } state_t;

    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

endpackage

// File: rtl/cmp_hysteresis_mon_cmp6.sv
// Behavioural DW01_cmp6: six-way magnitude compare, signed when TC = 1.
module DW01_cmp6 #(
    parameter int width = 8
) (
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    input  logic             TC,
    output logic             LT,
    output logic             GT,
    output logic             EQ,
    output logic             LE,
    output logic             GE,
    output logic             NE
);

    logic w_lt;

    always_comb begin
        if (TC) begin
            w_lt = $signed(A) < $signed(B);
        end else begin
            w_lt = A < B;
        end
    end

    assign EQ = (A == B);
    assign NE = !EQ;
    assign LT = w_lt;
    assign GE = !w_lt;
    assign LE = w_lt || EQ;
    assign GT = !w_lt && !EQ;

endmodule

// File: rtl/cmp_hysteresis_mon.sv
// Streaming high/low threshold monitor with persistence debounce and
// a valid/ready alarm-transition event port.
module cmp_hysteresis_mon
    import cmp_mon_pkg::*;
#(
    parameter int width       = 8,
    parameter int count_width = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [width-1:0]       sample,
    input  logic [width-1:0]       thresh_hi,
    input  logic [width-1:0]       thresh_lo,
    input  logic                   tc,
    input  logic [count_width-1:0] persist,
    output logic                   alarm,
    output logic [count_width-1:0] run_cnt,
    output logic                   evt_valid,
    output logic                   evt_rise,
    input  logic                   evt_ready
);

    localparam logic [count_width-1:0] CNT_ZERO = '0;
    localparam logic [count_width-1:0] CNT_ONE  =
        {{(count_width-1){1'b0}}, 1'b1};

    logic                   r_s1_valid;
    logic [width-1:0]       r_s1_sample;
    logic [width-1:0]       r_s1_hi;
    logic [width-1:0]       r_s1_lo;
    logic                   r_s1_tc;

    state_t                 r_state;
    state_t                 w_state_nx;
    logic [count_width-1:0] r_cnt;
    logic [count_width-1:0] w_cnt_nx;
    logic                   r_evt_valid;
    logic                   r_evt_rise;

    logic                   w_ge_hi;
    logic                   w_le_lo;
    logic [3:0]             w_hi_unused;
    logic [3:0]             w_lo_unused;
    logic                   w_stall;
    logic                   w_accept;
    logic                   w_consume;
    logic                   w_evt_gen;
    logic                   w_evt_dir;
    logic [count_width-1:0] w_p;
    logic                   w_p_one;
    logic                   w_run_done;

    DW01_cmp6 #(.width(width)) u_cmp_hi (
        .A  (r_s1_sample),
        .B  (r_s1_hi),
        .TC (r_s1_tc),
        .LT (w_hi_unused[0]),
        .GT (w_hi_unused[1]),
        .EQ (w_hi_unused[2]),
        .LE (w_hi_unused[3]),
        .GE (w_ge_hi),
        .NE ()
    );

    DW01_cmp6 #(.width(width)) u_cmp_lo (
        .A  (r_s1_sample),
        .B  (r_s1_lo),
        .TC (r_s1_tc),
        .LT (w_lo_unused[0]),
        .GT (w_lo_unused[1]),
        .EQ (w_lo_unused[2]),
        .LE (w_le_lo),
        .GE (w_lo_unused[3]),
        .NE ()
    );

    assign w_stall   = r_s1_valid && r_evt_valid && !evt_ready;
    assign in_ready  = !w_stall;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_s1_valid && !w_stall;

    // A persist of zero behaves as one; >= lets a lowered persist end a run.
    assign w_p        = (persist == CNT_ZERO) ? CNT_ONE : persist;
    assign w_p_one    = (w_p == CNT_ONE);
    assign w_run_done = ({1'b0, r_cnt} + 1'b1) >= {1'b0, w_p};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_hi     <= '0;
            r_s1_lo     <= '0;
            r_s1_tc     <= 1'b0;
        end else if (clear) begin
            r_s1_valid  <= 1'b0;
            r_s1_sample <= '0;
            r_s1_hi     <= '0;
            r_s1_lo     <= '0;
            r_s1_tc     <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid  <= 1'b1;
            r_s1_sample <= sample;
            r_s1_hi     <= thresh_hi;
            r_s1_lo     <= thresh_lo;
            r_s1_tc     <= tc;
        end else if (w_consume) begin
            r_s1_valid  <= 1'b0;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_evt_gen  = 1'b0;
        w_evt_dir  = EVT_FALL;
        if (w_consume) begin
            unique case (r_state)
                LOW: begin
                    if (w_ge_hi && w_p_one) begin
                        w_state_nx = HIGH;
                        w_cnt_nx   = CNT_ZERO;
                        w_evt_gen  = 1'b1;
                        w_evt_dir  = EVT_RISE;
                    end else if (w_ge_hi) begin
                        w_state_nx = ARM;
                        w_cnt_nx   = CNT_ONE;
                    end else begin
                        w_cnt_nx   = CNT_ZERO;
                    end
                end
                ARM: begin
                    if (w_ge_hi && w_run_done) begin
                        w_state_nx = HIGH;
                        w_cnt_nx   = CNT_ZERO;
                        w_evt_gen  = 1'b1;
                        w_evt_dir  = EVT_RISE;
                    end else if (w_ge_hi) begin
                        w_cnt_nx   = r_cnt + 1'b1;
                    end else begin
                        w_state_nx = LOW;
                        w_cnt_nx   = CNT_ZERO;
                    end
                end
                HIGH: begin
                    if (w_le_lo && w_p_one) begin
                        w_state_nx = LOW;
                        w_cnt_nx   = CNT_ZERO;
                        w_evt_gen  = 1'b1;
                        w_evt_dir  = EVT_FALL;
                    end else if (w_le_lo) begin
                        w_state_nx = DISARM;
                        w_cnt_nx   = CNT_ONE;
                    end
                end
                DISARM: begin
                    if (w_le_lo && w_run_done) begin
                        w_state_nx = LOW;
                        w_cnt_nx   = CNT_ZERO;
                        w_evt_gen  = 1'b1;
                        w_evt_dir  = EVT_FALL;
                    end else if (w_le_lo) begin
                        w_cnt_nx   = r_cnt + 1'b1;
                    end else begin
                        w_state_nx = HIGH;
                        w_cnt_nx   = CNT_ZERO;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else if (clear) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Events only generate when unstalled, so a pending one is never overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evt_valid <= 1'b0;
            r_evt_rise  <= 1'b0;
        end else if (clear) begin
            r_evt_valid <= 1'b0;
            r_evt_rise  <= 1'b0;
        end else if (w_evt_gen) begin
            r_evt_valid <= 1'b1;
            r_evt_rise  <= w_evt_dir;
        end else if (r_evt_valid && evt_ready) begin
            r_evt_valid <= 1'b0;
        end
    end

    assign alarm     = (r_state == HIGH) || (r_state == DISARM);
    assign run_cnt   = r_cnt;
    assign evt_valid = r_evt_valid;
    assign evt_rise  = r_evt_rise;

endmodule

// File: tb/tb_cmp_hysteresis_mon.sv
// Directed self-checking bench for cmp_hysteresis_mon.
module tb_cmp_hysteresis_mon;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] sample;
    logic [7:0] thresh_hi;
    logic [7:0] thresh_lo;
    logic       tc;
    logic [3:0] persist;
    logic       alarm;
    logic [3:0] run_cnt;
    logic       evt_valid;
    logic       evt_rise;
    logic       evt_ready;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_rise = 0;
    int n_fall = 0;

    cmp_hysteresis_mon #(.width(8), .count_width(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sample    (sample),
        .thresh_hi (thresh_hi),
        .thresh_lo (thresh_lo),
        .tc        (tc),
        .persist   (persist),
        .alarm     (alarm),
        .run_cnt   (run_cnt),
        .evt_valid (evt_valid),
        .evt_rise  (evt_rise),
        .evt_ready (evt_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (evt_rise) n_rise++;
            else n_fall++;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] s);
        @(negedge clk);
        in_valid = 1'b1;
        sample   = s;
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        sample    = 8'd0;
        thresh_hi = 8'd100;
        thresh_lo = 8'd50;
        tc        = 1'b0;
        persist   = 4'd3;
        evt_ready = 1'b1;
        #12;
        chk("rst_alarm", 32'(alarm), 0);
        chk("rst_cnt", 32'(run_cnt), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // rise after three qualifying samples
        send(8'd120);
        send(8'd120);
        chk("t1_cnt1", 32'(run_cnt), 1);
        send(8'd120);
        chk("t1_cnt2", 32'(run_cnt), 2);
        chk("t1_alarm_pre", 32'(alarm), 0);
        tick();
        chk("t1_alarm", 32'(alarm), 1);
        chk("t1_evt_valid", 32'(evt_valid), 1);
        chk("t1_evt_rise", 32'(evt_rise), 1);
        chk("t1_cnt0", 32'(run_cnt), 0);
        tick();
        chk("t1_evt_done", 32'(evt_valid), 0);
        chk("t1_n_rise", 32'(n_rise), 1);

        // interrupted fall run, then a real fall
        send(8'd40);
        send(8'd70);
        send(8'd40);
        tick();
        chk("t3_hold_alarm", 32'(alarm), 1);
        chk("t3_hold_cnt", 32'(run_cnt), 1);
        send(8'd70);
        send(8'd40);
        send(8'd40);
        send(8'd40);
        tick();
        chk("t3_alarm", 32'(alarm), 0);
        chk("t3_evt_valid", 32'(evt_valid), 1);
        chk("t3_evt_rise", 32'(evt_rise), 0);
        tick();
        chk("t3_n_fall", 32'(n_fall), 1);

        // run reset by an in-band sample
        send(8'd120);
        send(8'd120);
        send(8'd70);
        send(8'd120);
        send(8'd120);
        tick();
        chk("t2_alarm", 32'(alarm), 0);
        chk("t2_cnt", 32'(run_cnt), 2);
        send(8'd70);
        tick();
        chk("t2_cnt0", 32'(run_cnt), 0);
        chk("t2_n_rise", 32'(n_rise), 1);

        // signed thresholds
        tc        = 1'b1;
        thresh_hi = 8'hF6;
        thresh_lo = 8'hEC;
        send(8'h00);
        send(8'h00);
        send(8'h00);
        tick();
        chk("t4_s_rise", 32'(alarm), 1);
        send(8'hEC);
        send(8'hEC);
        send(8'hEC);
        tick();
        chk("t4_s_fall", 32'(alarm), 0);
        tc = 1'b0;
        send(8'h00);
        send(8'h00);
        send(8'h00);
        tick();
        tick();
        chk("t4_u_norise", 32'(alarm), 0);
        chk("t4_n_rise", 32'(n_rise), 2);
        chk("t4_n_fall", 32'(n_fall), 2);

        // back-pressure on the event port
        thresh_hi = 8'd100;
        thresh_lo = 8'd50;
        @(negedge clk);
        evt_ready = 1'b0;
        send(8'd120);
        send(8'd120);
        send(8'd120);
        tick();
        chk("t5_evt_valid", 32'(evt_valid), 1);
        send(8'd40);
        chk("t5_stall", 32'(in_ready), 0);
        tick();
        tick();
        chk("t5_hold_valid", 32'(evt_valid), 1);
        chk("t5_hold_rise", 32'(evt_rise), 1);
        chk("t5_hold_cnt", 32'(run_cnt), 0);
        chk("t5_hold_ready", 32'(in_ready), 0);
        @(negedge clk);
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_hs_valid", 32'(evt_valid), 0);
        chk("t5_hs_cnt", 32'(run_cnt), 1);
        chk("t5_hs_ready", 32'(in_ready), 1);
        chk("t5_n_rise", 32'(n_rise), 3);
        @(negedge clk);
        evt_ready = 1'b0;
        send(8'd40);
        send(8'd40);
        tick();
        chk("t5_fall_valid", 32'(evt_valid), 1);
        chk("t5_fall_dir", 32'(evt_rise), 0);
        chk("t5_fall_alarm", 32'(alarm), 0);
        @(negedge clk);
        evt_ready = 1'b1;
        tick();
        chk("t5_n_fall", 32'(n_fall), 3);
        chk("t5_n_rise2", 32'(n_rise), 3);

        // async reset mid-run
        send(8'd120);
        send(8'd120);
        tick();
        chk("t6_cnt2", 32'(run_cnt), 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rst_cnt", 32'(run_cnt), 0);
        chk("t6_rst_alarm", 32'(alarm), 0);
        chk("t6_rst_evt", 32'(evt_valid), 0);
        chk("t6_rst_ready", 32'(in_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // clear while stalled, handshake in the same cycle
        evt_ready = 1'b0;
        send(8'd120);
        send(8'd120);
        send(8'd120);
        tick();
        send(8'd40);
        chk("t6_stall", 32'(in_ready), 0);
        @(negedge clk);
        in_valid  = 1'b0;
        clear     = 1'b1;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_clr_alarm", 32'(alarm), 0);
        chk("t6_clr_evt", 32'(evt_valid), 0);
        chk("t6_clr_rise", 32'(evt_rise), 0);
        chk("t6_clr_n_rise", 32'(n_rise), 4);
        @(negedge clk);
        clear = 1'b0;
        tick();
        tick();
        chk("t6_lost_cnt", 32'(run_cnt), 0);
        chk("t6_lost_alarm", 32'(alarm), 0);
        chk("t6_lost_evt", 32'(evt_valid), 0);

        // persist of zero acts as one
        persist = 4'd0;
        send(8'd120);
        tick();
        chk("t6_p0_alarm", 32'(alarm), 1);
        chk("t6_p0_evt", 32'(evt_valid), 1);
        tick();
        chk("t6_p0_n_rise", 32'(n_rise), 5);
        chk("t6_p0_n_fall", 32'(n_fall), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
